// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access engine: data-path widths,
// memory op codes, FSM states and op classification helpers.
package mem_access_unit_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int BUS_SEL_W  = 4;
    localparam int MEM_OP_W   = 4;

    typedef logic [REG_BUS_W-1:0]  reg_bus_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;

    localparam logic          RST_ENABLE   = 1'b1;
    localparam reg_addr_bus_t REG_NOP_ADDR = '0;

    localparam logic [MEM_OP_W-1:0] MEM_OP_NONE = 4'd0;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LB   = 4'd1;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LBU  = 4'd2;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LH   = 4'd3;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LHU  = 4'd4;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LW   = 4'd5;
    localparam logic [MEM_OP_W-1:0] MEM_OP_SB   = 4'd6;
    localparam logic [MEM_OP_W-1:0] MEM_OP_SH   = 4'd7;
    localparam logic [MEM_OP_W-1:0] MEM_OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Unassigned op codes fall outside this range and behave like NONE.
    function automatic logic is_mem_op(input logic [MEM_OP_W-1:0] op);
        return (op >= MEM_OP_LB) && (op <= MEM_OP_SW);
    endfunction

    function automatic logic is_store_op(input logic [MEM_OP_W-1:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Big-endian byte-lane steering: lane select, store replication, load
// extraction with sign/zero extension, and alignment check.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [MEM_OP_W-1:0]  op,
    input  logic [1:0]           addr,
    input  logic [REG_BUS_W-1:0] sdata,
    input  logic [REG_BUS_W-1:0] rdata,
    output logic [BUS_SEL_W-1:0] sel,
    output logic [REG_BUS_W-1:0] wdata,
    output logic [REG_BUS_W-1:0] ldata,
    output logic                 misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane 0 (address offset 0) is the most significant byte on the bus.
    always_comb begin
        byte_v = rdata[31:24];
        case (addr)
            2'b00:   byte_v = rdata[31:24];
            2'b01:   byte_v = rdata[23:16];
            2'b10:   byte_v = rdata[15:8];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        sel      = '0;
        wdata    = '0;
        ldata    = '0;
        misalign = 1'b0;
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
                sel   = 4'b1000 >> addr;
                wdata = {4{sdata[7:0]}};
                ldata = (op == MEM_OP_LB) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
            end
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
                sel      = addr[1] ? 4'b0011 : 4'b1100;
                wdata    = {2{sdata[15:0]}};
                ldata    = (op == MEM_OP_LH) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
                misalign = addr[0];
            end
            MEM_OP_LW, MEM_OP_SW: begin
                sel      = 4'b1111;
                wdata    = sdata;
                ldata    = rdata;
                misalign = |addr;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access engine: runs one req/ack bus transaction per aligned
// load/store, stalls the pipeline meanwhile, and feeds MEM/WB.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [REG_BUS_W-1:0]  mem_wdata,
    input  logic [MEM_OP_W-1:0]   mem_op,
    input  logic [REG_BUS_W-1:0]  mem_addr,
    input  logic [REG_BUS_W-1:0]  mem_sdata,
    input  logic                  flush,
    output logic                  stall_req,
    output logic [REG_ADDR_W-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [REG_BUS_W-1:0]  wb_wdata,
    output logic                  excp_align,
    output logic                  bus_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [REG_BUS_W-1:0]  bus_addr,
    output logic [BUS_SEL_W-1:0]  bus_sel,
    output logic [REG_BUS_W-1:0]  bus_wdata,
    input  logic [REG_BUS_W-1:0]  bus_rdata,
    input  logic                  bus_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 flush_flag_q, flush_flag_d;
    logic                 bus_req_q, bus_req_d;
    logic                 bus_we_q, bus_we_d;
    logic [REG_BUS_W-1:0] bus_addr_q, bus_addr_d;
    logic [BUS_SEL_W-1:0] bus_sel_q, bus_sel_d;
    logic [REG_BUS_W-1:0] bus_wdata_q, bus_wdata_d;
    logic                 bus_err_q, bus_err_d;
    logic [REG_BUS_W-1:0] load_data_q, load_data_d;

    logic [BUS_SEL_W-1:0] align_sel;
    logic [REG_BUS_W-1:0] align_wdata;
    logic [REG_BUS_W-1:0] align_ldata;
    logic                 align_misalign;
    logic                 op_is_mem;
    logic                 op_is_store;

    assign op_is_mem   = is_mem_op(mem_op);
    assign op_is_store = is_store_op(mem_op);

    mem_lane_align u_lane_align (
        .op       (mem_op),
        .addr     (mem_addr[1:0]),
        .sdata    (mem_sdata),
        .rdata    (bus_rdata),
        .sel      (align_sel),
        .wdata    (align_wdata),
        .ldata    (align_ldata),
        .misalign (align_misalign)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_flag_d = flush_flag_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_sel_d    = bus_sel_q;
        bus_wdata_d  = bus_wdata_q;
        bus_err_d    = 1'b0;
        load_data_d  = load_data_q;
        case (state_q)
            ST_IDLE: begin
                flush_flag_d = 1'b0;
                if (op_is_mem && !align_misalign && !flush) begin
                    state_d     = ST_WAIT;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = op_is_store;
                    bus_addr_d  = {mem_addr[31:2], 2'b00};
                    bus_sel_d   = align_sel;
                    bus_wdata_d = align_wdata;
                end
            end
            // A flush here cannot cancel the bus cycle; it only blocks retirement.
            ST_WAIT: begin
                if (flush) begin
                    flush_flag_d = 1'b1;
                end
                if (bus_ack) begin
                    load_data_d = align_ldata;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    state_d     = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    bus_req_d    = 1'b0;
                    bus_we_d     = 1'b0;
                    bus_err_d    = 1'b1;
                    flush_flag_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                flush_flag_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            flush_flag_q <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_sel_q    <= '0;
            bus_wdata_q  <= '0;
            bus_err_q    <= 1'b0;
            load_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_flag_q <= flush_flag_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_sel_q    <= bus_sel_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_err_q    <= bus_err_d;
            load_data_q  <= load_data_d;
        end
    end

    // Pipeline-facing outputs are combinational so ALU results see no extra latency.
    always_comb begin
        stall_req  = 1'b0;
        wb_wd      = REG_NOP_ADDR;
        wb_wreg    = 1'b0;
        wb_wdata   = '0;
        excp_align = 1'b0;
        if (rst != RST_ENABLE) begin
            case (state_q)
                ST_IDLE: begin
                    if (!op_is_mem) begin
                        wb_wd    = mem_wd;
                        wb_wreg  = mem_wreg && !flush;
                        wb_wdata = mem_wdata;
                    end else if (!flush) begin
                        excp_align = align_misalign;
                        stall_req  = !align_misalign;
                    end
                end
                ST_WAIT: begin
                    stall_req = 1'b1;
                end
                ST_DONE: begin
                    if (!op_is_store) begin
                        wb_wd    = mem_wd;
                        wb_wreg  = !flush_flag_q && !flush;
                        wb_wdata = load_data_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_sel   = bus_sel_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT=4): each task runs one
// scenario and compares outputs against hand-computed values.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic        flush;
    logic        stall_req;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        excp_align;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .mem_sdata  (mem_sdata),
        .flush      (flush),
        .stall_req  (stall_req),
        .wb_wd      (wb_wd),
        .wb_wreg    (wb_wreg),
        .wb_wdata   (wb_wdata),
        .excp_align (excp_align),
        .bus_err    (bus_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_sel    (bus_sel),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_inputs;
        mem_op    = MEM_OP_NONE;
        mem_wd    = 5'd0;
        mem_wreg  = 1'b0;
        mem_wdata = 32'h0;
        mem_addr  = 32'h0;
        mem_sdata = 32'h0;
        flush     = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        set_idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_idle_inputs();
        mem_op = MEM_OP_LW; mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h1234; mem_addr = 32'h10;
        tick();
        tick();
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_stall: got %0h expected 0", stall_req); end
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_bus_req: got %0h expected 0", bus_req); end
        n_cmp++; if (bus_addr !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_bus_addr: got %h expected 0", bus_addr); end
        mem_op = MEM_OP_NONE;
        #1;
        n_cmp++; if (wb_wreg !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_wb_wreg: got %0h expected 0", wb_wreg); end
        n_cmp++; if (wb_wdata !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_wb_wdata: got %h expected 0", wb_wdata); end
        n_cmp++; if (bus_err !== 1'b0 || excp_align !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_pulses: got err=%0h align=%0h expected 0 0", bus_err, excp_align); end
        rst = 1'b0;
        set_idle_inputs();
    endtask

    task automatic test_back_to_back;
        do_reset();
        mem_op = MEM_OP_NONE; mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h55;
        #1;
        n_cmp++; if (wb_wd !== 5'd3) begin n_bad++; $display("[TB] FAIL alu_wb_wd: got %0d expected 3", wb_wd); end
        n_cmp++; if (wb_wreg !== 1'b1) begin n_bad++; $display("[TB] FAIL alu_wb_wreg: got %0h expected 1", wb_wreg); end
        n_cmp++; if (wb_wdata !== 32'h55) begin n_bad++; $display("[TB] FAIL alu_wb_wdata: got %h expected 00000055", wb_wdata); end
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("[TB] FAIL alu_stall: got %0h expected 0", stall_req); end
        tick();
        // ack held high already in IDLE must not short-circuit the transaction
        mem_op = MEM_OP_LBU; mem_addr = 32'h0; mem_wd = 5'd6; mem_wreg = 1'b1; mem_wdata = 32'hAAAA;
        bus_rdata = 32'h80000000; bus_ack = 1'b1;
        #1;
        n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("[TB] FAIL lbu_stall_idle: got %0h expected 1", stall_req); end
        n_cmp++; if (wb_wreg !== 1'b0) begin n_bad++; $display("[TB] FAIL lbu_wreg_idle: got %0h expected 0", wb_wreg); end
        tick();
        n_cmp++; if (bus_req !== 1'b1 || bus_we !== 1'b0) begin n_bad++; $display("[TB] FAIL lbu_bus_req: got req=%0h we=%0h expected 1 0", bus_req, bus_we); end
        n_cmp++; if (bus_sel !== 4'b1000) begin n_bad++; $display("[TB] FAIL lbu_bus_sel: got %b expected 1000", bus_sel); end
        n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("[TB] FAIL lbu_stall_wait: got %0h expected 1", stall_req); end
        tick();
        bus_ack = 1'b0;
        #1;
        n_cmp++; if (wb_wdata !== 32'h00000080) begin n_bad++; $display("[TB] FAIL lbu_wb_wdata: got %h expected 00000080", wb_wdata); end
        n_cmp++; if (wb_wreg !== 1'b1 || wb_wd !== 5'd6) begin n_bad++; $display("[TB] FAIL lbu_wb_dest: got wreg=%0h wd=%0d expected 1 6", wb_wreg, wb_wd); end
        n_cmp++; if (stall_req !== 1'b0 || bus_req !== 1'b0) begin n_bad++; $display("[TB] FAIL lbu_done: got stall=%0h req=%0h expected 0 0", stall_req, bus_req); end
        tick();
        set_idle_inputs();
        #1;
        n_cmp++; if (stall_req !== 1'b0 || bus_req !== 1'b0) begin n_bad++; $display("[TB] FAIL lbu_back_idle: got stall=%0h req=%0h expected 0 0", stall_req, bus_req); end
    endtask

    task automatic test_lb;
        do_reset();
        mem_op = MEM_OP_LB; mem_addr = 32'h103; mem_wd = 5'd9; mem_wreg = 1'b1; bus_rdata = 32'h112233F0;
        #1;
        n_cmp++; if (stall_req !== 1'b1) begin n_bad++; $display("[TB] FAIL lb_stall_c0: got %0h expected 1", stall_req); end
        tick();
        n_cmp++; if (bus_sel !== 4'b0001) begin n_bad++; $display("[TB] FAIL lb_bus_sel: got %b expected 0001", bus_sel); end
        n_cmp++; if (bus_addr !== 32'h100) begin n_bad++; $display("[TB] FAIL lb_bus_addr: got %h expected 00000100", bus_addr); end
        n_cmp++; if (stall_req !== 1'b1 || bus_req !== 1'b1) begin n_bad++; $display("[TB] FAIL lb_wait: got stall=%0h req=%0h expected 1 1", stall_req, bus_req); end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("[TB] FAIL lb_stall_done: got %0h expected 0", stall_req); end
        n_cmp++; if (wb_wdata !== 32'hFFFFFFF0) begin n_bad++; $display("[TB] FAIL lb_wb_wdata: got %h expected fffffff0", wb_wdata); end
        n_cmp++; if (wb_wreg !== 1'b1 || wb_wd !== 5'd9) begin n_bad++; $display("[TB] FAIL lb_wb_dest: got wreg=%0h wd=%0d expected 1 9", wb_wreg, wb_wd); end
        tick();
        set_idle_inputs();
    endtask

    task automatic test_sh_store;
        int stall_cycles;
        bit done;
        stall_cycles = 0;
        done = 1'b0;
        do_reset();
        mem_op = MEM_OP_SH; mem_addr = 32'h202; mem_sdata = 32'h0000ABCD; mem_wd = 5'd4; mem_wreg = 1'b1;
        #1;
        for (int c = 0; c < 10 && !done; c++) begin
            if (stall_req === 1'b1) begin
                stall_cycles++;
            end else begin
                done = 1'b1;
                n_cmp++; if (wb_wreg !== 1'b0) begin n_bad++; $display("[TB] FAIL sh_wb_wreg: got %0h expected 0", wb_wreg); end
                n_cmp++; if (bus_req !== 1'b0 || bus_we !== 1'b0) begin n_bad++; $display("[TB] FAIL sh_bus_drop: got req=%0h we=%0h expected 0 0", bus_req, bus_we); end
            end
            if (c == 1) begin
                n_cmp++; if (bus_we !== 1'b1) begin n_bad++; $display("[TB] FAIL sh_bus_we: got %0h expected 1", bus_we); end
                n_cmp++; if (bus_sel !== 4'b0011) begin n_bad++; $display("[TB] FAIL sh_bus_sel: got %b expected 0011", bus_sel); end
                n_cmp++; if (bus_wdata !== 32'hABCDABCD) begin n_bad++; $display("[TB] FAIL sh_bus_wdata: got %h expected abcdabcd", bus_wdata); end
                n_cmp++; if (bus_addr !== 32'h200) begin n_bad++; $display("[TB] FAIL sh_bus_addr: got %h expected 00000200", bus_addr); end
            end
            bus_ack = (c == 3);
            if (!done) tick();
        end
        n_cmp++; if (stall_cycles != 4 || !done) begin n_bad++; $display("[TB] FAIL sh_stall_cycles: got %0d (done=%0d) expected 4", stall_cycles, done); end
        bus_ack = 1'b0;
        tick();
        set_idle_inputs();
    endtask

    task automatic test_misalign;
        do_reset();
        mem_op = MEM_OP_LW; mem_addr = 32'h101; mem_wd = 5'd2; mem_wreg = 1'b1; bus_ack = 1'b1;
        #1;
        n_cmp++; if (excp_align !== 1'b1) begin n_bad++; $display("[TB] FAIL lw_mis_excp: got %0h expected 1", excp_align); end
        n_cmp++; if (stall_req !== 1'b0 || wb_wreg !== 1'b0) begin n_bad++; $display("[TB] FAIL lw_mis_stall_wreg: got stall=%0h wreg=%0h expected 0 0", stall_req, wb_wreg); end
        tick();
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("[TB] FAIL lw_mis_bus_req: got %0h expected 0", bus_req); end
        mem_op = MEM_OP_SH; mem_addr = 32'h203; bus_ack = 1'b0;
        #1;
        n_cmp++; if (excp_align !== 1'b1 || stall_req !== 1'b0) begin n_bad++; $display("[TB] FAIL sh_mis: got excp=%0h stall=%0h expected 1 0", excp_align, stall_req); end
        tick();
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("[TB] FAIL sh_mis_bus_req: got %0h expected 0", bus_req); end
        set_idle_inputs();
        #1;
        n_cmp++; if (excp_align !== 1'b0) begin n_bad++; $display("[TB] FAIL mis_pulse_end: got %0h expected 0", excp_align); end
    endtask

    task automatic test_timeout;
        int req_cycles;
        int err_pulses;
        req_cycles = 0;
        err_pulses = 0;
        do_reset();
        mem_op = MEM_OP_LW; mem_addr = 32'h40; mem_wd = 5'd11; mem_wreg = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_req === 1'b1) req_cycles++;
            if (bus_err === 1'b1) begin
                err_pulses++;
                n_cmp++; if (wb_wreg !== 1'b0 || stall_req !== 1'b0) begin n_bad++; $display("[TB] FAIL to_done: got wreg=%0h stall=%0h expected 0 0", wb_wreg, stall_req); end
                mem_op = MEM_OP_NONE;
                mem_wreg = 1'b0;
            end
        end
        n_cmp++; if (req_cycles != 4) begin n_bad++; $display("[TB] FAIL to_req_cycles: got %0d expected 4", req_cycles); end
        n_cmp++; if (err_pulses != 1) begin n_bad++; $display("[TB] FAIL to_err_pulses: got %0d expected 1", err_pulses); end
        n_cmp++; if (stall_req !== 1'b0 || bus_req !== 1'b0) begin n_bad++; $display("[TB] FAIL to_idle: got stall=%0h req=%0h expected 0 0", stall_req, bus_req); end
        set_idle_inputs();
    endtask

    task automatic test_flush;
        do_reset();
        mem_op = MEM_OP_LW; mem_addr = 32'h8; mem_wd = 5'd1; mem_wreg = 1'b1; flush = 1'b1;
        #1;
        n_cmp++; if (stall_req !== 1'b0 || wb_wreg !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_idle: got stall=%0h wreg=%0h expected 0 0", stall_req, wb_wreg); end
        tick();
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_idle_req: got %0h expected 0", bus_req); end
        flush = 1'b0;
        mem_op = MEM_OP_LHU; mem_addr = 32'h0; mem_wd = 5'd4; mem_wreg = 1'b1; bus_rdata = 32'hFFFF1234;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        n_cmp++; if (bus_req !== 1'b1 || stall_req !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_wait_hold: got req=%0h stall=%0h expected 1 1", bus_req, stall_req); end
        tick();
        n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_wait_hold2: got %0h expected 1", bus_req); end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        #1;
        n_cmp++; if (wb_wreg !== 1'b0 || bus_req !== 1'b0 || stall_req !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_done: got wreg=%0h req=%0h stall=%0h expected 0 0 0", wb_wreg, bus_req, stall_req); end
        tick();
        set_idle_inputs();
        mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h77;
        #1;
        n_cmp++; if (wb_wreg !== 1'b1 || wb_wdata !== 32'h77) begin n_bad++; $display("[TB] FAIL flush_after: got wreg=%0h wdata=%h expected 1 00000077", wb_wreg, wb_wdata); end
        set_idle_inputs();
    endtask

    task automatic test_load_extend;
        logic [3:0]  ops   [5] = '{MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW, MEM_OP_LB, MEM_OP_LBU};
        logic [31:0] addrs [5] = '{32'h2, 32'h2, 32'h8, 32'h1, 32'h2};
        logic [31:0] rdatas[5] = '{32'h00008001, 32'h00008001, 32'hDEADBEEF, 32'h00800000, 32'h0000FF00};
        logic [3:0]  sels  [5] = '{4'b0011, 4'b0011, 4'b1111, 4'b0100, 4'b0010};
        logic [31:0] exps  [5] = '{32'hFFFF8001, 32'h00008001, 32'hDEADBEEF, 32'hFFFFFF80, 32'h000000FF};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            mem_op = ops[k]; mem_addr = addrs[k]; bus_rdata = rdatas[k]; mem_wd = 5'd20; mem_wreg = 1'b1;
            tick();
            n_cmp++; if (bus_sel !== sels[k]) begin n_bad++; $display("[TB] FAIL ext_sel[%0d]: got %b expected %b", k, bus_sel, sels[k]); end
            bus_ack = 1'b1;
            tick();
            bus_ack = 1'b0;
            #1;
            n_cmp++; if (wb_wdata !== exps[k] || wb_wreg !== 1'b1) begin n_bad++; $display("[TB] FAIL ext_data[%0d]: got %h wreg=%0h expected %h 1", k, wb_wdata, wb_wreg, exps[k]); end
            tick();
            set_idle_inputs();
            tick();
        end
    endtask

    task automatic test_reset_mid_wait;
        do_reset();
        mem_op = MEM_OP_SW; mem_addr = 32'h4; mem_sdata = 32'hCAFEF00D;
        tick();
        n_cmp++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin n_bad++; $display("[TB] FAIL rmw_pre: got req=%0h we=%0h expected 1 1", bus_req, bus_we); end
        rst = 1'b1;
        #1;
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("[TB] FAIL rmw_stall: got %0h expected 0", stall_req); end
        tick();
        n_cmp++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rmw_ctrl: got req=%0h we=%0h err=%0h expected 0 0 0", bus_req, bus_we, bus_err); end
        n_cmp++; if (bus_addr !== 32'h0 || bus_sel !== 4'h0 || bus_wdata !== 32'h0) begin n_bad++; $display("[TB] FAIL rmw_bus: got addr=%h sel=%b wdata=%h expected 0 0 0", bus_addr, bus_sel, bus_wdata); end
        rst = 1'b0;
        set_idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        set_idle_inputs();
        test_reset();
        test_back_to_back();
        test_lb();
        test_sh_store();
        test_misalign();
        test_timeout();
        test_flush();
        test_load_extend();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
